// File: rtl/cell_op_scheduler.sv
// cell_op_scheduler: shares one bit-serial logic slice between NREQ requesters.
// A round-robin arbiter accepts one request in IDLE. The operands are loaded into
// shift registers and one result bit is produced per clock, LSB first. The tagged
// word is then presented for a single DONE cycle.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_req_valid/o_req_ready  per-requester handshake; o_req_ready is one-hot
//   i_req_op/a/b/sel         per-requester opcode and operand slices
//   o_resp_valid/id/data     one-cycle result strobe, requester id, result word
//   o_busy                   high whenever the scheduler is not idle
module cell_op_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [3*NREQ-1:0]       i_req_op,
  input  logic [WIDTH*NREQ-1:0]   i_req_a,
  input  logic [WIDTH*NREQ-1:0]   i_req_b,
  input  logic [WIDTH*NREQ-1:0]   i_req_sel,
  output logic                    o_resp_valid,
  output logic [IDW-1:0]          o_resp_id,
  output logic [WIDTH-1:0]        o_resp_data,
  output logic                    o_busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [IDW-1:0]     r_ptr;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_sel;
  logic [2:0]         r_op;
  logic [IDW-1:0]     r_id;
  logic [WIDTH-2:0]   r_res;  // partial result; the final bit joins it on the last shift
  logic [WIDTH-1:0]   r_resp_data;
  logic [IDW-1:0]     r_resp_id;

  logic               w_any, w_hi_found, w_last, w_bit;
  logic [IDW-1:0]     w_hi_id, w_lo_id, w_win;
  logic [NREQ-1:0]    w_hi_oh, w_lo_oh, w_oh;
  logic [WIDTH-1:0]   w_a, w_b, w_sel, w_res_shift;
  logic [2:0]         w_op;

  function automatic logic cell_eval(input logic [2:0] op, input logic a, input logic b,
                                     input logic s);
    case (op)
      3'd0:    return a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~a;
      3'd6:    return s ? b : a;
      default: return 1'b0;
    endcase
  endfunction

  // Round-robin: lowest valid index above the pointer wins, otherwise the lowest
  // valid index at or below it (wrap-around).
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_id    = '0;
    w_lo_id    = '0;
    w_hi_oh    = '0;
    w_lo_oh    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        if (i > int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_id    = IDW'(i);
          w_hi_oh    = '0;
          w_hi_oh[i] = 1'b1;
        end else begin
          w_lo_id    = IDW'(i);
          w_lo_oh    = '0;
          w_lo_oh[i] = 1'b1;
        end
      end
    end
    w_any = |i_req_valid;
    w_win = w_hi_found ? w_hi_id : w_lo_id;
    w_oh  = w_hi_found ? w_hi_oh : w_lo_oh;
  end

  // Operand select driven by the one-hot grant.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sel = '0;
    w_op  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_oh[i]) begin
        w_a   = i_req_a[i*WIDTH +: WIDTH];
        w_b   = i_req_b[i*WIDTH +: WIDTH];
        w_sel = i_req_sel[i*WIDTH +: WIDTH];
        w_op  = i_req_op[i*3 +: 3];
      end
    end
  end

  assign w_bit       = cell_eval(r_op, r_a[0], r_b[0], r_sel[0]);
  assign w_res_shift = {w_bit, r_res};
  assign w_last      = (r_cnt == CntW'(WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_any) w_state_next = StShift;
      StShift: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_ptr       <= IDW'(NREQ - 1);
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= '0;
      r_op        <= '0;
      r_id        <= '0;
      r_res       <= '0;
      r_resp_data <= '0;
      r_resp_id   <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_a   <= w_a;
            r_b   <= w_b;
            r_sel <= w_sel;
            r_op  <= w_op;
            r_id  <= w_win;
            r_ptr <= w_win;
            r_cnt <= '0;
          end
        end
        StShift: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_sel <= r_sel >> 1;
          r_res <= w_res_shift[WIDTH-1:1];
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_resp_data <= w_res_shift;
            r_resp_id   <= r_id;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so no grant is offered while the block is held in reset.
  assign o_req_ready  = (r_state == StIdle && i_rst_n) ? w_oh : '0;
  assign o_resp_valid = (r_state == StDone);
  assign o_resp_id    = r_resp_id;
  assign o_resp_data  = r_resp_data;
  assign o_busy       = (r_state != StIdle);

endmodule
